// File: rtl/draw_card_grid_pkg.sv
// rtl/draw_card_grid_pkg.sv - default geometry, colours and helpers shared by the card-grid renderer
package draw_card_grid_pkg;

   localparam int COLS_D         = 18;
   localparam int ROWS_D         = 8;
   localparam int TYPE_W_D       = 6;
   localparam int CARD_W_D       = 32;
   localparam int CARD_H_D       = 55;
   localparam int X0_D           = 32;
   localparam int Y0_D           = 19;
   localparam int SPLIT_ROW_D    = 6;
   localparam int SPLIT_GAP_D    = 11;
   localparam int BLINK_FRAMES_D = 30;
   localparam logic [11:0] HL_COLOR_D = 12'hF00;

   localparam int EMPTY_TYPE = 0;
   localparam int COL_W      = 5;
   localparam int ROW_W      = 3;
   localparam int POS_W      = 6;
   localparam int PIX_W      = 12;

   typedef struct packed {
      logic [COL_W-1:0] col;
      logic [ROW_W-1:0] row;
      logic [POS_W-1:0] px;
      logic [POS_W-1:0] py;
   } grid_pos_t;

   function automatic logic on_border(input logic [POS_W-1:0] px, input logic [POS_W-1:0] py,
                                      input int w, input int h);
      return (int'(px) < 2) || (int'(px) >= w - 2) || (int'(py) < 2) || (int'(py) >= h - 2);
   endfunction

endpackage

// File: rtl/draw_card_grid_if.sv
// rtl/draw_card_grid_if.sv - card-image ROM address/data bus
interface draw_card_grid_if #(
   parameter int TYPE_W = 6
) ();
   logic [TYPE_W-1:0] rom_type;
   logic [5:0]        rom_x;
   logic [5:0]        rom_y;
   logic [11:0]       rom_data;

   modport master (output rom_type, output rom_x, output rom_y, input rom_data);
   modport slave  (input rom_type, input rom_x, input rom_y, output rom_data);
endinterface

// File: rtl/draw_card_grid_axis.sv
// rtl/draw_card_grid_axis.sv - card index / in-card pixel counter for one screen axis
module draw_card_grid_axis #(
   parameter int IDX_W = 5,
   parameter int POS_W = 6,
   parameter int SIZE  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [IDX_W-1:0] load_idx_i,
   input  logic             step_i,
   output logic [IDX_W-1:0] idx_o,
   output logic [POS_W-1:0] pos_o
);
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [POS_W-1:0] pos_q, pos_d;

   always_comb begin
      idx_d = idx_q;
      pos_d = pos_q;
      if (load_i) begin
         idx_d = load_idx_i;
         pos_d = '0;
      end else if (step_i) begin
         if (pos_q == POS_W'(SIZE - 1)) begin
            pos_d = '0;
            idx_d = idx_q + 1'b1;
         end else begin
            pos_d = pos_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
         pos_q <= '0;
      end else if (en_i) begin
         idx_q <= idx_d;
         pos_q <= pos_d;
      end
   end

   assign idx_o = idx_q;
   assign pos_o = pos_q;
endmodule

// File: rtl/draw_card_grid.sv
// rtl/draw_card_grid.sv - three-stage card-grid pixel renderer with blinking selection border
module draw_card_grid
   import draw_card_grid_pkg::*;
#(
   parameter int          COLS         = COLS_D,
   parameter int          ROWS         = ROWS_D,
   parameter int          TYPE_W       = TYPE_W_D,
   parameter int          CARD_W       = CARD_W_D,
   parameter int          CARD_H       = CARD_H_D,
   parameter int          X0           = X0_D,
   parameter int          Y0           = Y0_D,
   parameter int          SPLIT_ROW    = SPLIT_ROW_D,
   parameter int          SPLIT_GAP    = SPLIT_GAP_D,
   parameter int          BLINK_FRAMES = BLINK_FRAMES_D,
   parameter logic [11:0] HL_COLOR     = HL_COLOR_D
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pix_en,
   input  logic [9:0]                  h_cnt,
   input  logic [9:0]                  v_cnt,
   input  logic [ROWS*COLS*TYPE_W-1:0] map,
   input  logic [4:0]                  sel_col,
   input  logic [2:0]                  sel_row,
   output logic [PIX_W-1:0]            card_pixel,
   output logic                        card_valid,
   draw_card_grid_if.master            rom
);
   localparam int NSLOT   = ROWS * COLS;
   localparam int SLOT_W  = $clog2(NSLOT);
   localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
   localparam int Y_SPLIT_I = Y0 + SPLIT_ROW * CARD_H + SPLIT_GAP;

   localparam logic [9:0] X_LO      = 10'(X0);
   localparam logic [9:0] X_HI      = 10'(X0 + COLS * CARD_W);
   localparam logic [9:0] Y_LO      = 10'(Y0);
   localparam logic [9:0] Y_TOP_END = 10'(Y0 + SPLIT_ROW * CARD_H);
   localparam logic [9:0] Y_SPLIT   = 10'(Y_SPLIT_I);
   localparam logic [9:0] Y_BOT_END = 10'(Y_SPLIT_I + (ROWS - SPLIT_ROW) * CARD_H);

   logic line_start, frame_start, in_gap, x_in, y_in;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [POS_W-1:0] px, py;
   grid_pos_t pos;

   logic [TYPE_W-1:0] shadow_q [NSLOT];
   logic              in_q, in_d;
   logic [TYPE_W-1:0] rom_type_q, rom_type_d;
   logic [POS_W-1:0]  rom_x_q, rom_x_d, rom_y_q, rom_y_d;
   logic              hl_q, hl_d;
   logic [PIX_W-1:0]  card_pixel_q, card_pixel_d;
   logic              card_valid_q, card_valid_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic              blink_on_q, blink_on_d;
   logic [SLOT_W-1:0] slot;
   logic [TYPE_W-1:0] slot_type;
   logic              sel_ok;

   assign line_start  = pix_en && (h_cnt == 10'd0);
   assign frame_start = line_start && (v_cnt == 10'd0);
   assign in_gap      = (v_cnt >= Y_TOP_END) && (v_cnt < Y_SPLIT);
   assign x_in        = (h_cnt >= X_LO) && (h_cnt < X_HI);
   assign y_in        = ((v_cnt >= Y_LO) && (v_cnt < Y_TOP_END)) ||
                        ((v_cnt >= Y_SPLIT) && (v_cnt < Y_BOT_END));

   draw_card_grid_axis #(.IDX_W(COL_W), .POS_W(POS_W), .SIZE(CARD_W)) u_axis_x (
      .clk        (clk),
      .rst        (rst),
      .en_i       (pix_en),
      .load_i     (h_cnt == X_LO),
      .load_idx_i ('0),
      .step_i     (1'b1),
      .idx_o      (col),
      .pos_o      (px)
   );

   // The lower block is loaded directly at its first line, so the gap lines just hold.
   draw_card_grid_axis #(.IDX_W(ROW_W), .POS_W(POS_W), .SIZE(CARD_H)) u_axis_y (
      .clk        (clk),
      .rst        (rst),
      .en_i       (line_start),
      .load_i     ((v_cnt == Y_LO) || (v_cnt == Y_SPLIT)),
      .load_idx_i ((v_cnt == Y_SPLIT) ? ROW_W'(SPLIT_ROW) : '0),
      .step_i     (!in_gap),
      .idx_o      (row),
      .pos_o      (py)
   );

   always_comb begin
      pos       = '{col: col, row: row, px: px, py: py};
      in_d      = x_in && y_in;
      slot      = SLOT_W'(int'(pos.row) * COLS + int'(pos.col));
      slot_type = in_q ? shadow_q[slot] : TYPE_W'(EMPTY_TYPE);
      sel_ok    = (int'(sel_col) < COLS) && (int'(sel_row) < ROWS);

      rom_type_d = slot_type;
      rom_x_d    = (slot_type != TYPE_W'(EMPTY_TYPE)) ? pos.px : '0;
      rom_y_d    = (slot_type != TYPE_W'(EMPTY_TYPE)) ? pos.py : '0;
      hl_d       = in_q && sel_ok && (pos.row == sel_row) && (pos.col == sel_col) &&
                   on_border(pos.px, pos.py, CARD_W, CARD_H) && blink_on_q;

      // rom_data answers the address registered one strobe earlier, aligned with hl_q.
      card_valid_d = hl_q || (rom_type_q != TYPE_W'(EMPTY_TYPE));
      card_pixel_d = hl_q ? HL_COLOR :
                     ((rom_type_q != TYPE_W'(EMPTY_TYPE)) ? rom.rom_data : '0);

      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      if (frame_start) begin
         if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            blink_on_d  = !blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_q         <= 1'b0;
         rom_type_q   <= '0;
         rom_x_q      <= '0;
         rom_y_q      <= '0;
         hl_q         <= 1'b0;
         card_pixel_q <= '0;
         card_valid_q <= 1'b0;
         blink_cnt_q  <= '0;
         blink_on_q   <= 1'b1;
         for (int i = 0; i < NSLOT; i++) shadow_q[i] <= '0;
      end else if (pix_en) begin
         in_q         <= in_d;
         rom_type_q   <= rom_type_d;
         rom_x_q      <= rom_x_d;
         rom_y_q      <= rom_y_d;
         hl_q         <= hl_d;
         card_pixel_q <= card_pixel_d;
         card_valid_q <= card_valid_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_on_q   <= blink_on_d;
         if (frame_start) begin
            for (int i = 0; i < NSLOT; i++) shadow_q[i] <= map[i*TYPE_W +: TYPE_W];
         end
      end
   end

   assign rom.rom_type = rom_type_q;
   assign rom.rom_x    = rom_x_q;
   assign rom.rom_y    = rom_y_q;
   assign card_pixel   = card_pixel_q;
   assign card_valid   = card_valid_q;
endmodule

// File: tb/tb_draw_card_grid.sv
// tb/tb_draw_card_grid.sv - directed bench for draw_card_grid with a registered ROM model
module tb_draw_card_grid;
   localparam int ROWS = 8;
   localparam int COLS = 18;

   logic clk = 1'b0;
   logic rst, pix_en;
   logic [9:0] h_cnt, v_cnt;
   logic [ROWS*COLS*6-1:0] map;
   logic [4:0] sel_col;
   logic [2:0] sel_row;
   logic [11:0] card_pixel;
   logic card_valid;

   int n_assert = 0;
   int n_fail = 0;
   logic [5:0] r_type, r_x, r_y;
   logic [11:0] c_pix;
   logic c_val;

   draw_card_grid_if #(.TYPE_W(6)) rom_bus ();

   draw_card_grid #(.BLINK_FRAMES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_en     (pix_en),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .map        (map),
      .sel_col    (sel_col),
      .sel_row    (sel_row),
      .card_pixel (card_pixel),
      .card_valid (card_valid),
      .rom        (rom_bus)
   );

   always #5 clk = ~clk;

   // ROM image: pixel encodes {type, x, y} low nibbles, one clock behind the address.
   always @(posedge clk)
      rom_bus.rom_data <= {rom_bus.rom_type[3:0], rom_bus.rom_x[3:0], rom_bus.rom_y[3:0]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input int h, input int v);
      @(negedge clk);
      h_cnt  = 10'(h);
      v_cnt  = 10'(v);
      pix_en = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
   endtask

   task automatic lines(input int v_from, input int v_to);
      for (int v = v_from; v <= v_to; v++) strobe(0, v);
   endtask

   task automatic walk(input int v, input int h_t);
      for (int h = 32; h <= h_t + 2; h++) begin
         strobe(h, v);
         if (h == h_t + 1) begin
            r_type = rom_bus.rom_type;
            r_x    = rom_bus.rom_x;
            r_y    = rom_bus.rom_y;
         end
      end
      c_pix = card_pixel;
      c_val = card_valid;
   endtask

   task automatic hl_check(input string tag, input logic [4:0] scol, input logic vis);
      sel_col = scol;
      sel_row = 3'd2;
      lines(19, 129);
      walk(129, 128);
      chk({tag, "_tl_pix"}, c_pix, vis ? 12'hF00 : 12'h000);
      chk({tag, "_tl_val"}, c_val, vis);
      lines(130, 131);
      walk(131, 130);
      chk({tag, "_inner_val"}, c_val, 1'b0);
      walk(131, 158);
      chk({tag, "_right_pix"}, c_pix, vis ? 12'hF00 : 12'h000);
      sel_col = 5'd20;
   endtask

   initial begin
      rst = 1'b1; pix_en = 1'b0; h_cnt = '0; v_cnt = '0;
      sel_col = 5'd20; sel_row = 3'd0;
      map = '0;
      map[0*6 +: 6]   = 6'd5;
      map[1*6 +: 6]   = 6'd7;
      map[108*6 +: 6] = 6'd9;
      repeat (3) @(negedge clk);
      chk("rst_pix", card_pixel, 12'h000);
      chk("rst_val", card_valid, 1'b0);
      chk("rst_rtype", rom_bus.rom_type, 6'd0);
      chk("rst_rx", rom_bus.rom_x, 6'd0);
      chk("rst_ry", rom_bus.rom_y, 6'd0);
      rst = 1'b0;

      hl_check("f0_hl", 5'd3, 1'b1);
      hl_check("f0_nosel", 5'd20, 1'b0);

      strobe(0, 0);
      lines(19, 19);
      walk(19, 32);
      chk("first_rtype", r_type, 6'd5);
      chk("first_rx", r_x, 6'd0);
      chk("first_ry", r_y, 6'd0);
      chk("first_pix", c_pix, 12'h500);
      chk("first_val", c_val, 1'b1);
      walk(19, 63);
      chk("h63_rtype", r_type, 6'd5);
      chk("h63_rx", r_x, 6'd31);
      chk("h63_pix", c_pix, 12'h5F0);
      walk(19, 64);
      chk("h64_rtype", r_type, 6'd7);
      chk("h64_rx", r_x, 6'd0);
      chk("h64_pix", c_pix, 12'h700);

      lines(349, 349);
      walk(349, 32);
      chk("gap349_val", c_val, 1'b0);
      chk("gap349_rtype", r_type, 6'd0);
      lines(359, 359);
      walk(359, 32);
      chk("gap359_val", c_val, 1'b0);
      chk("gap359_pix", c_pix, 12'h000);
      lines(360, 360);
      walk(360, 32);
      chk("v360_rtype", r_type, 6'd9);
      chk("v360_ry", r_y, 6'd0);
      chk("v360_pix", c_pix, 12'h900);
      lines(361, 361);
      walk(361, 33);
      chk("v361_rx", r_x, 6'd1);
      chk("v361_ry", r_y, 6'd1);
      chk("v361_pix", c_pix, 12'h911);

      map[0*6 +: 6] = 6'd3;
      lines(19, 19);
      walk(19, 32);
      chk("tear_rtype", r_type, 6'd5);
      chk("tear_pix", c_pix, 12'h500);
      hl_check("f1_hl", 5'd3, 1'b1);

      strobe(0, 0);
      lines(19, 19);
      walk(19, 32);
      chk("newmap_rtype", r_type, 6'd3);
      chk("newmap_pix", c_pix, 12'h300);
      hl_check("f2_hl", 5'd3, 1'b0);
      strobe(0, 0);
      hl_check("f3_hl", 5'd3, 1'b0);
      strobe(0, 0);
      hl_check("f4_hl", 5'd3, 1'b1);
      strobe(0, 0);
      hl_check("f5_hl", 5'd3, 1'b1);
      strobe(0, 0);
      hl_check("f6_hl", 5'd3, 1'b0);

      lines(19, 19);
      walk(19, 32);
      @(negedge clk);
      h_cnt = 10'd500; v_cnt = 10'd200; map = '0; sel_col = 5'd0; sel_row = 3'd0;
      repeat (10) @(negedge clk);
      chk("frz_pix", card_pixel, 12'h300);
      chk("frz_val", card_valid, 1'b1);
      chk("frz_rtype", rom_bus.rom_type, 6'd3);
      chk("frz_rx", rom_bus.rom_x, 6'd1);
      sel_col = 5'd20;
      map[0*6 +: 6] = 6'd3;

      h_cnt = 10'd40; v_cnt = 10'd19; pix_en = 1'b1; rst = 1'b1;
      @(negedge clk);
      pix_en = 1'b0; rst = 1'b0;
      chk("mrst_pix", card_pixel, 12'h000);
      chk("mrst_val", card_valid, 1'b0);
      chk("mrst_rtype", rom_bus.rom_type, 6'd0);
      chk("mrst_rx", rom_bus.rom_x, 6'd0);
      chk("mrst_ry", rom_bus.rom_y, 6'd0);
      lines(19, 19);
      walk(19, 32);
      chk("empty_shadow_val", c_val, 1'b0);
      chk("empty_shadow_rtype", r_type, 6'd0);
      strobe(0, 0);
      lines(19, 19);
      walk(19, 32);
      chk("refill_rtype", r_type, 6'd3);
      chk("refill_pix", c_pix, 12'h300);
      hl_check("post_rst_hl", 5'd3, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/draw_card_grid.md
DRAW_CARD_GRID -- requirements
Module: draw_card_grid

Interface
REQ-001 Parameter COLS, default 18: card columns per row.
REQ-002 Parameter ROWS, default 8: card rows.
REQ-003 Parameter TYPE_W, default 6: card-type code width; code 0 means empty slot.
REQ-004 Parameter CARD_W, default 32; CARD_H, default 55: card size in pixels.
REQ-005 Parameter X0, default 32; Y0, default 19: top-left pixel of row 0 col 0.
REQ-006 Parameter SPLIT_ROW, default 6; SPLIT_GAP, default 11: blank lines inserted before row SPLIT_ROW.
REQ-007 Parameter BLINK_FRAMES, default 30: frames per highlight blink half-period.
REQ-008 Parameter HL_COLOR, default 12'hF00: highlight border colour.
REQ-009 clk input 1: system clock. Synchronous, active-high reset, single clock domain.
REQ-010 rst input 1: synchronous active-high reset.
REQ-011 pix_en input 1: one-cycle pixel strobe (25 MHz rate); all state advances only when high.
REQ-012 h_cnt input 10 and v_cnt input 10: current VGA raster position.
REQ-013 map input ROWS*COLS*TYPE_W: slot i = row*COLS+col at bits [i*TYPE_W +: TYPE_W].
REQ-014 sel_col input 5 and sel_row input 3: highlighted slot.
REQ-015 rom_type output TYPE_W; rom_x output 6; rom_y output 6: card-image ROM address.
REQ-016 rom_data input 12: ROM pixel, valid exactly one pix_en cycle after the address.
REQ-017 card_pixel output 12: composed RGB444 pixel.
REQ-018 card_valid output 1: card_pixel is an opaque card pixel.

Function
REQ-019 Grid region: X0 <= h_cnt < X0+COLS*CARD_W; rows 0..SPLIT_ROW-1 from Y0 upward, rows SPLIT_ROW..ROWS-1 start at Y0+SPLIT_ROW*CARD_H+SPLIT_GAP.
REQ-020 Column index and pixel_x are produced by counters, not dividers: cleared at h_cnt==X0, pixel_x wraps CARD_W-1 -> 0 with column+1.
REQ-021 Row index and pixel_y update once per line (pix_en with h_cnt==0), same wrap rule on CARD_H; no increment inside the gap.
REQ-022 Map shadow: map is copied to an internal register on pix_en with h_cnt==0 and v_cnt==0; lookups use only the shadow (no mid-frame tearing).
REQ-023 Pipeline: stage 1 computes indices/in-grid; stage 2 registers slot type and drives rom_*; stage 3 composes output. Latency: 3 pix_en strobes from h_cnt/v_cnt to card_pixel.
REQ-024 Outside grid or gap, or slot type 0: card_pixel=0, card_valid=0, rom_* = 0.
REQ-025 Highlight: if slot == (sel_row, sel_col), pixel on 2-pixel border (pixel_x<2, >=CARD_W-2, pixel_y<2, >=CARD_H-2) and blink_on==1, card_pixel=HL_COLOR, card_valid=1, even for type 0.
REQ-026 sel_col>=COLS or sel_row>=ROWS: no highlight anywhere.
REQ-027 Blink counter increments at each frame start; on reaching BLINK_FRAMES-1 it clears and blink_on toggles.
REQ-028 pix_en low: all registers hold; outputs stable.

Reset
REQ-029 On rst: all pipeline regs, counters, map shadow, blink counter cleared; blink_on=1; card_pixel=0, card_valid=0, rom_*=0 on the next edge.
REQ-030 Reset mid-frame: outputs stay 0 until the pipeline refills (3 pix_en strobes); shadow remains all-empty until the next frame start.

Structure
REQ-031 Shared package holds default geometry constants, HL_COLOR, and the empty-type code 0.
REQ-032 One sub-module draw_card_grid_axis (counter/wrap for one axis) instantiated for X and Y.

Verification
REQ-033 Frame start with map slot 0=5, h=32,v=19 -> after 3 strobes rom_type=5, rom_x=0, rom_y=0; card_pixel=rom_data, card_valid=1.
REQ-034 h=63 -> 64 -> column 0 pixel_x 31 then column 1 pixel_x 0; v=349..359 -> card_valid=0; v=360 -> row 6 pixel_y 0.
REQ-035 map changed mid-frame -> output unchanged until next v=0,h=0 strobe.
REQ-036 sel=(2,3), slot empty, blink_on=1 -> border pixels = 12'hF00, interior card_valid=0; sel_col=20 -> no highlight.
REQ-037 BLINK_FRAMES=2 -> highlight visible frames 0-1, hidden 2-3, visible 4-5.
REQ-038 rst asserted mid-line -> next edge all outputs 0; pix_en held low -> outputs frozen.
